// File: rtl/gain_pkg.sv
// Shared constants and types for the fixed-coefficient gain stage.
package gain_pkg;
  localparam int DATA_W    = 8;
  localparam int GAIN_W    = 8;
  localparam int GAIN_FRAC = 4;
  localparam logic signed [GAIN_W-1:0] GAIN = 8'sd32;

  localparam int PROD_W  = DATA_W + GAIN_W;
  localparam int OUT_MAX = (1 << (DATA_W-1)) - 1;
  localparam int OUT_MIN = -(1 << (DATA_W-1));

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [PROD_W-1:0] prod_t;
endpackage

// File: rtl/gain_if.sv
// Sample stream bundle for the gain stage: producer drives data_in, consumer takes data_out.
interface gain_if;
  import gain_pkg::*;
  sample_t data_in;
  sample_t data_out;

  modport master (output data_in, input  data_out);
  modport slave  (input  data_in, output data_out);
endinterface

// File: rtl/gain_round_sat.sv
// Combinational round-half-up and 8-bit reduction of the full-width product.
// Reduction is clamp when GAIN_SATURATE_EN is defined, two's-complement wrap otherwise.
module gain_round_sat
  import gain_pkg::*;
#(
  parameter int FRAC = GAIN_FRAC
) (
  input  prod_t   i_prod,
  output sample_t o_data
);
  // One guard bit above the product keeps the rounding add from overflowing.
  typedef logic signed [PROD_W:0] ext_t;

  ext_t w_rnd;

  generate
    if (FRAC == 0) begin : g_no_round
      assign w_rnd = ext_t'(i_prod);
    end else begin : g_round
      ext_t w_sum;
      assign w_sum = ext_t'(i_prod) + (ext_t'(1) <<< (FRAC-1));
      assign w_rnd = w_sum >>> FRAC;
    end
  endgenerate

`ifdef GAIN_SATURATE_EN
  logic w_sat;
  assign w_sat  = (w_rnd > ext_t'(OUT_MAX)) || (w_rnd < ext_t'(OUT_MIN));
  assign o_data = w_sat ? (w_rnd[PROD_W] ? sample_t'(OUT_MIN) : sample_t'(OUT_MAX))
                        : w_rnd[DATA_W-1:0];
`else
  logic w_unused;
  assign w_unused = ^w_rnd[PROD_W:DATA_W];
  assign o_data   = w_rnd[DATA_W-1:0];
`endif
endmodule

// File: rtl/gain_stage.sv
// Two-stage fixed gain: register the full product, then round/reduce into o_data.
// Overflow handling selected by macro GAIN_SATURATE_EN (clamp) vs. default wrap.
module gain_stage #(
  parameter int GAIN_FRAC = gain_pkg::GAIN_FRAC,
  parameter logic signed [gain_pkg::GAIN_W-1:0] GAIN = gain_pkg::GAIN
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  gain_pkg::sample_t i_data,
  output gain_pkg::sample_t o_data
);
  import gain_pkg::*;

  prod_t   r_prod;
  prod_t   w_prod;
  sample_t w_out;

  assign w_prod = prod_t'(i_data) * prod_t'(GAIN);

  gain_round_sat #(.FRAC(GAIN_FRAC)) u_round_sat (
    .i_prod (r_prod),
    .o_data (w_out)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_prod <= '0;
      o_data <= '0;
    end else begin
      r_prod <= w_prod;
      o_data <= w_out;
    end
  end
endmodule

// File: tb/tb_gain_stage.sv
// Directed bench: three gain_stage instances (2.0, 1.5, -1.0) with shared clock/reset.
module tb_gain_stage;
  import gain_pkg::*;

`ifdef GAIN_SATURATE_EN
  localparam int OVF_POS = 127;
  localparam int OVF_NEG = -128;
  localparam int NEG_EXP = 127;
`else
  localparam int OVF_POS = -56;
  localparam int OVF_NEG = 56;
  localparam int NEG_EXP = -128;
`endif

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  sample_t d24, dn16, q24, qn16;
  int      checks = 0;
  int      errors = 0;

  gain_if u_if ();

  always #5 clk = ~clk;

  gain_stage #(.GAIN(8'sd32)) u_g32 (
    .i_clk(clk), .i_reset_n(rst_n), .i_data(u_if.data_in), .o_data(u_if.data_out));
  gain_stage #(.GAIN(8'sd24)) u_g24 (
    .i_clk(clk), .i_reset_n(rst_n), .i_data(d24), .o_data(q24));
  gain_stage #(.GAIN(-8'sd16)) u_gn16 (
    .i_clk(clk), .i_reset_n(rst_n), .i_data(dn16), .o_data(qn16));

  function automatic int dout(input int sel);
    case (sel)
      0:       return int'(u_if.data_out);
      1:       return int'(q24);
      default: return int'(qn16);
    endcase
  endfunction

  task automatic drive(input int sel, input int v);
    case (sel)
      0:       u_if.data_in = sample_t'(v);
      1:       d24 = sample_t'(v);
      default: dn16 = sample_t'(v);
    endcase
  endtask

  task automatic test_reset();
    drive(0, 55); drive(1, 0); drive(2, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
        checks++;
        if (dout(s) !== 0) begin
          errors++;
          $display("FAIL reset_hold[%0d] dut%0d: got %0d expected 0", i, s, dout(s));
        end
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (dout(0) !== 0) begin
      errors++;
      $display("FAIL reset_first_edge: got %0d expected 0", dout(0));
    end
    @(negedge clk);
    checks++;
    if (dout(0) !== 110) begin
      errors++;
      $display("FAIL reset_first_sample: got %0d expected 110", dout(0));
    end
  endtask

  task automatic test_nominal();
    int xs[3] = '{10, -20, 0};
    int ex[3] = '{20, -40, 0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if (dout(0) !== ex[i-2]) begin
          errors++;
          $display("FAIL nominal[%0d]: got %0d expected %0d", i-2, dout(0), ex[i-2]);
        end
      end
      drive(0, (i < 3) ? xs[i] : 0);
    end
  endtask

  task automatic test_overflow();
    int xs[2] = '{100, -100};
    int ex[2] = '{OVF_POS, OVF_NEG};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if (dout(0) !== ex[i-2]) begin
          errors++;
          $display("FAIL overflow[%0d]: got %0d expected %0d", i-2, dout(0), ex[i-2]);
        end
      end
      drive(0, (i < 2) ? xs[i] : 0);
    end
  endtask

  task automatic test_rounding();
    int xs[4] = '{3, -3, 1, -1};
    int ex[4] = '{5, -4, 2, -1};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if (dout(1) !== ex[i-2]) begin
          errors++;
          $display("FAIL rounding[%0d]: got %0d expected %0d", i-2, dout(1), ex[i-2]);
        end
      end
      drive(1, (i < 4) ? xs[i] : 0);
    end
  endtask

  task automatic test_negative_gain();
    int xs[2] = '{-128, 5};
    int ex[2] = '{NEG_EXP, -5};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if (dout(2) !== ex[i-2]) begin
          errors++;
          $display("FAIL neg_gain[%0d]: got %0d expected %0d", i-2, dout(2), ex[i-2]);
        end
      end
      drive(2, (i < 2) ? xs[i] : 0);
    end
  endtask

  task automatic test_midstream_reset();
    int xs[10];
    foreach (xs[k]) xs[k] = int'($urandom_range(120, 0)) - 60;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if (dout(0) !== 2 * xs[i-2]) begin
          errors++;
          $display("FAIL stream[%0d]: got %0d expected %0d", i-2, dout(0), 2 * xs[i-2]);
        end
      end
      drive(0, xs[i]); drive(1, xs[i]); drive(2, xs[i]);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (dout(s) !== 0) begin
        errors++;
        $display("FAIL async_clear dut%0d: got %0d expected 0", s, dout(s));
      end
    end
    @(negedge clk);
    drive(0, 13);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (dout(0) !== 0) begin
      errors++;
      $display("FAIL post_reset_flush: got %0d expected 0", dout(0));
    end
    @(negedge clk);
    checks++;
    if (dout(0) !== 26) begin
      errors++;
      $display("FAIL post_reset_first: got %0d expected 26", dout(0));
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_overflow();
    test_rounding();
    test_negative_gain();
    test_midstream_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
